// File: rtl/fifo_uart_pkg.sv
// Shared types and default sizing for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int unsigned DEFAULT_WIDTH        = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned    CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == CNT_MAX)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_c = (cnt == CNT_MAX) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from an upstream first-word-fall-through FIFO.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] read_data,
    output logic             pop,
    output logic             tx,
    output logic             busy
);

    localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    tx_state_e        state;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next_c;
    logic [IDX_W-1:0] bit_idx;
    logic             parity_q;
    logic             tick_c;

    // The FIFO is read only from IDLE, so pop can never repeat on consecutive cycles.
    assign pop          = (state == IDLE) && enable && !fifo_empty && rst_n;
    assign shift_next_c = shift_q >> 1;

    // Held clear in IDLE so every frame starts on a full bit period; later
    // state changes all coincide with the counter wrapping to zero.
    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == IDLE),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            shift_q  <= '0;
            bit_idx  <= '0;
            parity_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        shift_q  <= read_data;
                        parity_q <= ^read_data;
                        bit_idx  <= '0;
                    end
                end
                START: begin
                    if (tick_c) begin
                        state <= DATA;
                        tx    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick_c) begin
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= parity_q;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shift_q <= shift_next_c;
                            tx      <= shift_next_c[0];
                        end
                    end
                end
                PARITY: begin
                    if (tick_c) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick_c) begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: two transmitters (no parity / even parity) fed by queue-style FIFO models.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int W   = 8;
    localparam int FL0 = (2 + W) * CPB;
    localparam int FL1 = (3 + W) * CPB;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    int cyc = 0;

    logic       fifo_empty0, fifo_empty1;
    logic [7:0] read_data0, read_data1;
    logic       pop0, pop1, tx0, tx1, busy0, busy1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (pop0) rd0 <= rd0 + 1;
    always @(posedge clk) if (pop1) rd1 <= rd1 + 1;

    assign fifo_empty0 = (rd0 == wr0);
    assign fifo_empty1 = (rd1 == wr1);
    assign read_data0  = mem0[rd0[7:0]];
    assign read_data1  = mem1[rd1[7:0]];

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty0),
        .read_data(read_data0), .pop(pop0), .tx(tx0), .busy(busy0)
    );

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty1),
        .read_data(read_data1), .pop(pop1), .tx(tx1), .busy(busy1)
    );

    // Reference: expected line level k cycles after the pop edge of a frame.
    function automatic logic model_tx(input logic [7:0] w, input bit pe, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= W) return w[slot-1];
        if (pe && slot == W + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic push0(input logic [7:0] v);
        mem0[wr0[7:0]] = v;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [7:0] v);
        mem1[wr1[7:0]] = v;
        wr1 = wr1 + 1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        push0(8'hA5);
        repeat (3) @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || pop0 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0 || pop1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b/%b busy=%b/%b pop=%b/%b required tx=1 busy=0 pop=0",
                     tx0, tx1, busy0, busy1, pop0, pop1);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (pop0 !== 1'b1 || pop1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_pop: pop=%b/%b required 1/0", pop0, pop1);
        end
    endtask

    // Word 0xA5 was queued during reset; the frame follows the first edge after release.
    task automatic test_single();
        int t = 0;
        while (pop0 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (pop0 !== 1'b1) begin errors++; $display("FAIL single_pop: pop=%b required 1", pop0); end
        for (int k = 0; k < FL0; k++) begin
            @(negedge clk);
            checks++;
            if (tx0 !== model_tx(8'hA5, 1'b0, k) || busy0 !== 1'b1 || pop0 !== 1'b0) begin
                errors++;
                $display("FAIL single_frame k=%0d: tx=%b busy=%b pop=%b required tx=%b busy=1 pop=0",
                         k, tx0, busy0, pop0, model_tx(8'hA5, 1'b0, k));
            end
        end
        @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || pop0 !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: tx=%b busy=%b pop=%b required 1 0 0", tx0, busy0, pop0);
        end
    endtask

    task automatic test_back_to_back(input int nwords, input bit fixed);
        logic [7:0] words[$];
        int t, last_pop;
        words = {};
        for (int i = 0; i < nwords; i++) begin
            logic [7:0] v;
            v = fixed ? 8'(i + 1) : 8'($urandom_range(0, 255));
            words.push_back(v);
        end
        @(negedge clk);
        foreach (words[i]) push0(words[i]);
        enable = 1'b1;
        #1;
        last_pop = 0;
        for (int i = 0; i < nwords; i++) begin
            t = 0;
            while (pop0 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
            checks++;
            if (pop0 !== 1'b1) begin errors++; $display("FAIL b2b_pop word=%0d: pop=%b required 1", i, pop0); end
            if (i > 0) begin
                checks++;
                if (cyc - last_pop !== FL0 + 1) begin
                    errors++;
                    $display("FAIL b2b_spacing word=%0d: spacing=%0d required %0d", i, cyc - last_pop, FL0 + 1);
                end
            end
            last_pop = cyc;
            for (int k = 0; k < FL0; k++) begin
                @(negedge clk);
                checks++;
                if (tx0 !== model_tx(words[i], 1'b0, k) || busy0 !== 1'b1 || pop0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_frame word=%0d k=%0d: tx=%b busy=%b pop=%b required tx=%b busy=1 pop=0",
                             i, k, tx0, busy0, pop0, model_tx(words[i], 1'b0, k));
                end
                if (k == 0 && i == nwords - 1) begin
                    checks++;
                    if (fifo_empty0 !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_drained: fifo_empty=%b required 1", fifo_empty0);
                    end
                end
            end
        end
        @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || pop0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: tx=%b busy=%b pop=%b required 1 0 0", tx0, busy0, pop0);
        end
    endtask

    task automatic test_parity(input logic [7:0] w);
        int t = 0;
        @(negedge clk);
        push1(w);
        enable = 1'b1;
        #1;
        while (pop1 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (pop1 !== 1'b1) begin errors++; $display("FAIL parity_pop: pop=%b required 1", pop1); end
        for (int k = 0; k < FL1; k++) begin
            @(negedge clk);
            checks++;
            if (tx1 !== model_tx(w, 1'b1, k) || busy1 !== 1'b1 || pop1 !== 1'b0) begin
                errors++;
                $display("FAIL parity_frame w=%h k=%0d: tx=%b busy=%b pop=%b required tx=%b busy=1 pop=0",
                         w, k, tx1, busy1, pop1, model_tx(w, 1'b1, k));
            end
        end
        @(negedge clk);
        checks++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || pop1 !== 1'b0) begin
            errors++;
            $display("FAIL parity_idle: tx=%b busy=%b pop=%b required 1 0 0", tx1, busy1, pop1);
        end
    endtask

    task automatic test_gating();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        @(negedge clk);
        enable = 1'b0;
        push0(w);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if (pop0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL gating_hold c=%0d: pop=%b tx=%b busy=%b required 0 1 0", c, pop0, tx0, busy0);
            end
        end
        enable = 1'b1;
        #1;
        checks++;
        if (pop0 !== 1'b1) begin errors++; $display("FAIL gating_release: pop=%b required 1", pop0); end
        for (int k = 0; k < FL0; k++) begin
            @(negedge clk);
            checks++;
            if (tx0 !== model_tx(w, 1'b0, k) || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL gating_frame k=%0d: tx=%b busy=%b required tx=%b busy=1",
                         k, tx0, busy0, model_tx(w, 1'b0, k));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [7:0] w;
        int t = 0;
        w = 8'($urandom_range(0, 255));
        @(negedge clk);
        push0(w);
        enable = 1'b1;
        #1;
        while (pop0 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (pop0 !== 1'b1) begin errors++; $display("FAIL abort_pop: pop=%b required 1", pop0); end
        // Cycle 17 after the pop edge falls inside data bit 3.
        for (int k = 0; k <= 4 * CPB + 1; k++) @(negedge clk);
        checks++;
        if (tx0 !== w[3] || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_bit3: tx=%b busy=%b required tx=%b busy=1", tx0, busy0, w[3]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || pop0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: tx=%b busy=%b pop=%b required 1 0 0", tx0, busy0, pop0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (pop0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL abort_after c=%0d: pop=%b tx=%b busy=%b required 0 1 0", c, pop0, tx0, busy0);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] w0, w1;
        int t = 0;
        w0 = 8'($urandom_range(0, 255));
        w1 = 8'($urandom_range(0, 255));
        @(negedge clk);
        push0(w0);
        push0(w1);
        enable = 1'b1;
        #1;
        while (pop0 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (pop0 !== 1'b1) begin errors++; $display("FAIL drop_pop: pop=%b required 1", pop0); end
        for (int k = 0; k < FL0; k++) begin
            @(negedge clk);
            if (k == 0) enable = 1'b0;
            checks++;
            if (tx0 !== model_tx(w0, 1'b0, k) || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL drop_frame k=%0d: tx=%b busy=%b required tx=%b busy=1",
                         k, tx0, busy0, model_tx(w0, 1'b0, k));
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (pop0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL drop_wait c=%0d: pop=%b tx=%b busy=%b required 0 1 0", c, pop0, tx0, busy0);
            end
        end
        enable = 1'b1;
        #1;
        checks++;
        if (pop0 !== 1'b1) begin errors++; $display("FAIL drop_resume: pop=%b required 1", pop0); end
        for (int k = 0; k < FL0; k++) begin
            @(negedge clk);
            checks++;
            if (tx0 !== model_tx(w1, 1'b0, k) || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL drop_frame2 k=%0d: tx=%b busy=%b required tx=%b busy=1",
                         k, tx0, busy0, model_tx(w1, 1'b0, k));
            end
        end
        @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || pop0 !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: tx=%b busy=%b pop=%b required 1 0 0", tx0, busy0, pop0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back(3, 1'b1);
        for (int r = 0; r < 3; r++) test_back_to_back(int'($urandom_range(1, 4)), 1'b0);
        test_parity(8'h07);
        test_parity(8'h03);
        for (int r = 0; r < 3; r++) test_parity(8'($urandom_range(0, 255)));
        test_gating();
        test_reset_abort();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per frame and width of the FIFO word consumed.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range is 2 or more.
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  permits fetching a new word; level-sensitive.
REQ-007 SHALL have port fifo_empty  input  1  upstream FWFT FIFO empty flag.
REQ-008 SHALL have port read_data  input  WIDTH  upstream FWFT head word, valid whenever fifo_empty=0.
REQ-009 SHALL have port pop  output  1  one-cycle read strobe to the upstream FIFO.
REQ-010 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 pop SHALL equal (state==IDLE) AND enable AND NOT fifo_empty AND rst_n, combinationally; it SHALL never be high for two consecutive cycles.
REQ-014 On the rising edge where pop=1, the block SHALL load read_data into the shift register, move to START, and drive tx=0 from the next cycle.
REQ-015 START SHALL hold tx=0 for exactly CLKS_PER_BIT cycles.
REQ-016 DATA SHALL send WIDTH bits LSB first, each held CLKS_PER_BIT cycles; the bit index wraps to 0 on exit.
REQ-017 PARITY SHALL be entered only when PARITY_EN=1 and SHALL send the XOR of the data bits for CLKS_PER_BIT cycles; with PARITY_EN=0, DATA SHALL go directly to STOP.
REQ-018 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 Frame length SHALL be (2+WIDTH+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-020 Back-to-back pops SHALL be spaced by frame length + 1 cycle, because of one IDLE cycle between frames.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 tx SHALL be 1 in IDLE.
REQ-023 Deasserting enable mid-frame SHALL let the current frame complete; no further pop occurs until enable=1 in IDLE.
REQ-024 fifo_empty=1 in IDLE SHALL keep the block in IDLE with pop=0; read_data is then ignored.
REQ-025 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and reset to 0 on every state change.

Reset
REQ-026 While rst_n=0, the block SHALL force state=IDLE, tx=1, busy=0 and pop=0, and SHALL clear the baud counter, bit index and shift register.
REQ-027 Reset mid-frame SHALL take tx to 1 immediately (asynchronously); the popped word is discarded and not re-requested.
REQ-028 After rst_n rises, the first pop SHALL occur no earlier than the first rising edge with enable=1 and fifo_empty=0.

Structure
REQ-029 A package fifo_uart_pkg SHALL hold the tx_state_e enum typedef (IDLE, START, DATA, PARITY, STOP) and the default WIDTH and CLKS_PER_BIT constants.
REQ-030 One sub-module, uart_baud_counter, SHALL generate the end-of-bit tick; it takes clk, rst_n, a clear input and CLKS_PER_BIT.
REQ-031 The block SHALL connect pop, read_data and fifo_empty directly to the existing FWFT FIFO pop, read_data and fifo_empty ports, with no glue logic.

Verification (CLKS_PER_BIT=4, WIDTH=8 unless stated)
REQ-032 Single word: FIFO holds 0xA5, enable=1 -> one pop pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles; busy high for 40 cycles.
REQ-033 Back-to-back: FIFO preloaded with 0x01, 0x02, 0x03 -> three pops exactly 41 cycles apart; frames in order; fifo_empty=1 after the third pop.
REQ-034 Parity: PARITY_EN=1, word 0x07 -> parity bit 1; frame 44 cycles; then word 0x03 -> parity bit 0.
REQ-035 Gating: FIFO non-empty, enable=0 for 100 cycles -> pop=0 and tx=1 throughout; enable=1 -> pop on the next edge.
REQ-036 Reset abort: assert rst_n=0 during DATA bit 3 -> tx=1 and busy=0 in the same cycle; after release with an empty FIFO -> no pop, tx stays 1.
REQ-037 Enable drop: enable=0 during START of a frame with 2 words queued -> the frame completes; no second pop until enable returns.
